// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake with timeout/retry,
// latches the returned word and computes the next PC when the datapath retires it.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   input  logic        advance,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   input  logic [31:0] branchOffset,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instrValid,
   output logic [31:0] pc,
   output logic [31:0] pcPlus4,
   output logic        fetchErr
);

   localparam int unsigned CntW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {StBoot, StFetch, StRetry, StHold} fetchState_e;

   fetchState_e     stateQ, stateD;
   logic [31:0]     pcQ, pcD;
   logic [31:0]     instrQ, instrD;
   logic            validQ, validD;
   logic [CntW-1:0] cntQ, cntD;
   logic            errQ, errD;
   logic [31:0]     nextPc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= StBoot;
         pcQ    <= RESET_PC;
         instrQ <= 32'h0;
         validQ <= 1'b0;
         cntQ   <= '0;
         errQ   <= 1'b0;
      end else begin
         stateQ <= stateD;
         pcQ    <= pcD;
         instrQ <= instrD;
         validQ <= validD;
         cntQ   <= cntD;
         errQ   <= errD;
      end
   end

   // Jump takes priority so that X on branch/zero during a j never reaches the PC.
   always_comb begin
      nextPc = pcPlus4;
      if (jump) begin
         nextPc = {pcPlus4[31:28], instrQ[25:0], 2'b00};
      end else if (branch && zero) begin
         nextPc = pcPlus4 + {branchOffset[29:0], 2'b00};
      end
   end

   always_comb begin
      stateD = stateQ;
      pcD    = pcQ;
      instrD = instrQ;
      validD = validQ;
      cntD   = cntQ;
      errD   = 1'b0;
      case (stateQ)
         StBoot: stateD = StFetch;
         StFetch: begin
            if (imemAck) begin
               instrD = imemData;
               validD = 1'b1;
               cntD   = '0;
               stateD = StHold;
            end else if (cntQ == CntW'(TIMEOUT - 1)) begin
               // Drop req for one cycle so memory sees a fresh request.
               errD   = 1'b1;
               cntD   = '0;
               stateD = StRetry;
            end else begin
               cntD = cntQ + 1'b1;
            end
         end
         StRetry: stateD = StFetch;
         StHold: begin
            if (advance) begin
               validD = 1'b0;
               pcD    = {nextPc[31:2], 2'b00};
               stateD = StFetch;
            end
         end
         default: stateD = StBoot;
      endcase
   end

   assign imemReq    = (stateQ == StFetch);
   assign imemAddr   = pcQ;
   assign pc         = pcQ;
   assign pcPlus4    = pcQ + 32'd4;
   assign instr      = instrQ;
   assign opcode     = instrQ[31:26];
   assign instrValid = validQ;
   assign fetchErr   = errQ;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: sequential fetch, beq, j, wrap,
// ack timeout/retry and reset mid-fetch.
module tb_instr_fetch;

   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck = 1'b0;
   logic [31:0] imemData = 32'h0;
   logic        advance = 1'b0;
   logic        jump = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic [31:0] branchOffset = 32'h0;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instrValid;
   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic        fetchErr;

   int checks = 0;
   int errors = 0;

   instr_fetch #(
      .RESET_PC(32'h0000_0000),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imemReq     (imemReq),
      .imemAddr    (imemAddr),
      .imemAck     (imemAck),
      .imemData    (imemData),
      .advance     (advance),
      .jump        (jump),
      .branch      (branch),
      .zero        (zero),
      .branchOffset(branchOffset),
      .instr       (instr),
      .opcode      (opcode),
      .instrValid  (instrValid),
      .pc          (pc),
      .pcPlus4     (pcPlus4),
      .fetchErr    (fetchErr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   // Wait for req, check address, ack after 'delay' cycles, then check the latched word.
   task automatic doFetch(input logic [31:0] expAddr, input logic [31:0] data, input int delay,
                          input string name);
      int n = 0;
      while (imemReq !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (imemReq !== 1'b1) begin
         errors++;
         $display("FAIL %s req: imemReq=%b want 1", name, imemReq);
         return;
      end
      checks++;
      if (imemAddr !== expAddr) begin
         errors++;
         $display("FAIL %s addr: imemAddr=%h want %h", name, imemAddr, expAddr);
      end
      repeat (delay) @(negedge clk);
      imemAck  = 1'b1;
      imemData = data;
      @(negedge clk);
      imemAck  = 1'b0;
      imemData = 32'hDEAD_BEEF;
      checks++;
      if (instr !== data) begin
         errors++;
         $display("FAIL %s instr: instr=%h want %h", name, instr, data);
      end
      checks++;
      if (opcode !== data[31:26]) begin
         errors++;
         $display("FAIL %s opcode: opcode=%h want %h", name, opcode, data[31:26]);
      end
      checks++;
      if (instrValid !== 1'b1 || imemReq !== 1'b0) begin
         errors++;
         $display("FAIL %s hold: instrValid=%b imemReq=%b want 1/0", name, instrValid, imemReq);
      end
   endtask

   task automatic doAdvance(input logic j, input logic b, input logic z, input logic [31:0] off);
      advance      = 1'b1;
      jump         = j;
      branch       = b;
      zero         = z;
      branchOffset = off;
      @(negedge clk);
      advance      = 1'b0;
      jump         = 1'b0;
      branch       = 1'b0;
      zero         = 1'b0;
      branchOffset = 32'h0;
      checks++;
      if (instrValid !== 1'b0) begin
         errors++;
         $display("FAIL advance valid: instrValid=%b want 0", instrValid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (imemReq !== 1'b0 || pc !== 32'h0 || instrValid !== 1'b0 || fetchErr !== 1'b0
          || instr !== 32'h0) begin
         errors++;
         $display("FAIL reset: req=%b pc=%h valid=%b err=%b instr=%h want 0/0/0/0/0",
                  imemReq, pc, instrValid, fetchErr, instr);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_sequential();
      doFetch(32'h0, 32'h2001_0005, 0, "seq0");
      checks++;
      if (pcPlus4 !== 32'h4) begin
         errors++;
         $display("FAIL seq pcPlus4: pcPlus4=%h want 00000004", pcPlus4);
      end
      // Ack while holding must be ignored.
      imemAck  = 1'b1;
      imemData = 32'hFFFF_FFFF;
      @(negedge clk);
      imemAck  = 1'b0;
      checks++;
      if (instr !== 32'h2001_0005 || instrValid !== 1'b1) begin
         errors++;
         $display("FAIL hold ack ignored: instr=%h valid=%b want 20010005/1", instr, instrValid);
      end
      doAdvance(1'b0, 1'b0, 1'b0, 32'h0);
      doFetch(32'h4, 32'h8C22_0004, 1, "seq4");
      doAdvance(1'b0, 1'b0, 1'b0, 32'h0);
      doFetch(32'h8, 32'h0043_2020, 2, "seq8");
   endtask

   task automatic test_branch();
      // 0xC + 13*4 = 0x40
      doAdvance(1'b0, 1'b1, 1'b1, 32'd13);
      doFetch(32'h40, 32'h1000_FFFE, 0, "beq40");
      doAdvance(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
      doFetch(32'h3C, 32'h0000_0020, 0, "beqBack");
      doAdvance(1'b0, 1'b0, 1'b0, 32'h0);
      doFetch(32'h40, 32'h1000_FFFE, 0, "beq40b");
      doAdvance(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE);
      doFetch(32'h44, 32'h0000_0021, 0, "beqNotTaken");
   endtask

   task automatic test_jump();
      // 0x48 + 0x03FF_FFF2*4 = 0x1000_0010
      doAdvance(1'b0, 1'b1, 1'b1, 32'h03FF_FFF2);
      doFetch(32'h1000_0010, {6'h02, 26'h000_0100}, 1, "jmpSrc");
      doAdvance(1'b1, 1'bx, 1'bx, 32'h1234_5678);
      doFetch(32'h1000_0400, 32'h0000_0022, 0, "jmpDst");
   endtask

   task automatic test_wrap();
      // 0x1000_0404 + 0x3BFF_FEFE*4 = 0xFFFF_FFFC
      doAdvance(1'b0, 1'b1, 1'b1, 32'h3BFF_FEFE);
      doFetch(32'hFFFF_FFFC, 32'h0000_0023, 0, "wrapSrc");
      checks++;
      if (pcPlus4 !== 32'h0) begin
         errors++;
         $display("FAIL wrap pcPlus4: pcPlus4=%h want 00000000", pcPlus4);
      end
      doAdvance(1'b0, 1'b0, 1'b0, 32'h0);
      doFetch(32'h0, 32'h0000_0024, 0, "wrapDst");
   endtask

   task automatic test_timeout();
      int reqBad = 0;
      doAdvance(1'b0, 1'b0, 1'b0, 32'h0);
      // Req rose this cycle; it must stay high for TIMEOUT cycles without ack.
      for (int i = 0; i < TIMEOUT; i++) begin
         if (imemReq !== 1'b1 || fetchErr !== 1'b0 || pc !== 32'h4) reqBad++;
         advance = (i % 3 == 1);
         @(negedge clk);
      end
      advance = 1'b0;
      checks++;
      if (reqBad != 0) begin
         errors++;
         $display("FAIL timeout wait: %0d bad cycles, want 0", reqBad);
      end
      checks++;
      if (imemReq !== 1'b0 || fetchErr !== 1'b1) begin
         errors++;
         $display("FAIL timeout abort: req=%b err=%b want 0/1", imemReq, fetchErr);
      end
      @(negedge clk);
      checks++;
      if (imemReq !== 1'b1 || fetchErr !== 1'b0 || imemAddr !== 32'h4) begin
         errors++;
         $display("FAIL timeout retry: req=%b err=%b addr=%h want 1/0/00000004",
                  imemReq, fetchErr, imemAddr);
      end
      doFetch(32'h4, 32'h0000_0025, 1, "retry");
   endtask

   task automatic test_reset_mid_fetch();
      doAdvance(1'b0, 1'b0, 1'b0, 32'h0);
      advance = 1'b1;
      @(negedge clk);
      advance = 1'b0;
      checks++;
      if (imemReq !== 1'b1 || pc !== 32'h8) begin
         errors++;
         $display("FAIL fetch advance ignored: req=%b pc=%h want 1/00000008", imemReq, pc);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (imemReq !== 1'b0 || pc !== 32'h0 || instrValid !== 1'b0) begin
         errors++;
         $display("FAIL async reset: req=%b pc=%h valid=%b want 0/00000000/0",
                  imemReq, pc, instrValid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      doFetch(32'h0, 32'h0000_0026, 0, "afterReset");
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_wrap();
      test_timeout();
      test_reset_mid_fetch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
